// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter:
// FSM encoding, digit-adjust constants and the iteration-counter width helper.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // The counter must be able to hold BIN_W itself, hence the +1.
  function automatic int cnt_width(input int n_iter);
    int w;
    w = $clog2(n_iter + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Per-digit "add 3 if >= 5" correction used before each double-dabble shift.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // 4-bit wrap is intentional: no carry leaves the digit.
  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// start/done handshake, sticky result registers and a top-digit overflow flag.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = cnt_width(BIN_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shreg;
  logic [BW-1:0]      r_scratch;
  logic [BW-1:0]      w_adj;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf_acc;
  logic               r_ovf;
  logic               w_accept;
  logic               w_last;
  logic               w_ovf_nxt;
  logic [BW+BIN_W-1:0] w_cat_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift the combined {scratch, shreg} left by one.
  assign w_cat_sh  = {w_adj, r_shreg} << 1;
  assign w_ovf_nxt = r_ovf_acc | w_adj[BW-1];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_shreg   <= bin_in;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_scratch <= w_cat_sh[BW+BIN_W-1:BIN_W];
      r_shreg   <= w_cat_sh[BIN_W-1:0];
      r_cnt     <= r_cnt + CW'(1);
      r_ovf_acc <= w_ovf_nxt;
      if (w_last) begin
        r_bcd <= w_cat_sh[BW+BIN_W-1:BIN_W];
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: arithmetic reference model for 3- and 2-digit instances,
// directed literal cases, back-to-back, mid-run reset, sweep and random traffic.
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin_in = 8'd0;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Low d decimal digits of v, packed 4 bits per digit.
  function automatic logic [31:0] bcd_of(input int v, input int d);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      r = r | (32'((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: remaining iterations, captured operand, last result.
  int   m_left;
  int   m_val;
  int   m_res;
  logic m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_val  <= 0;
      m_res  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_res  <= m_val;
        end
      end else if (start) begin
        m_val  <= int'(bin_in);
        m_left <= BIN_W;
      end
    end
  end

  always @(negedge clk) begin
    check("busy3",  32'(busy3), 32'(m_left > 0));
    check("done3",  32'(done3), 32'(m_done));
    check("bcd3",   32'(bcd3),  bcd_of(m_res, 3));
    check("ovf3",   32'(ovf3),  32'(m_res >= 1000));
    check("busy2",  32'(busy2), 32'(m_left > 0));
    check("done2",  32'(done2), 32'(m_done));
    check("bcd2",   32'(bcd2),  bcd_of(m_res, 2));
    check("ovf2",   32'(ovf2),  32'(m_res >= 100));
  end

  // Called between edges; returns just after the edge that raises done.
  task automatic run_conv(input logic [7:0] v, input bit noise,
                          output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy3) busy_n++;
      if (noise) begin
        start  = 1'($urandom);
        bin_in = 8'($urandom);
      end
      @(posedge clk);
      edges++;
      #1;
      if (done3) break;
    end
    start = 1'b0;
    check("done_seen", 32'(done3), 32'd1);
  endtask

  initial begin
    int e, b;
    time t1, t2;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_bcd",  32'(bcd3),  32'd0);
    check("rst_ovf",  32'(ovf3),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_conv(8'd0, 1'b0, e, b);
    check("lat_0",   32'(e), 32'd8);
    check("busy_0",  32'(b), 32'd8);
    check("bcd_0",   32'(bcd3), 32'h000);
    check("ovf_0",   32'(ovf3), 32'd0);
    @(posedge clk); #1;

    run_conv(8'd255, 1'b0, e, b);
    check("bcd_255",  32'(bcd3), 32'h255);
    check("ovf_255",  32'(ovf3), 32'd0);
    check("bcd2_255", 32'(bcd2), 32'h55);
    check("ovf2_255", 32'(ovf2), 32'd1);
    @(posedge clk); #1;

    run_conv(8'd99, 1'b0, e, b);
    check("bcd_99",  32'(bcd3), 32'h099);
    check("bcd2_99", 32'(bcd2), 32'h99);
    check("ovf2_99", 32'(ovf2), 32'd0);
    @(posedge clk); #1;

    run_conv(8'd100, 1'b0, e, b);
    check("bcd_100",  32'(bcd3), 32'h100);
    check("ovf2_100", 32'(ovf2), 32'd1);
    @(posedge clk); #1;

    run_conv(8'd173, 1'b1, e, b);
    check("lat_noise", 32'(e), 32'd8);
    check("bcd_noise", 32'(bcd3), 32'h173);
    repeat (3) @(posedge clk);
    #1;

    run_conv(8'd37, 1'b0, e, b);
    t1 = $time;
    check("bcd_37", 32'(bcd3), 32'h037);
    run_conv(8'd200, 1'b0, e, b);
    t2 = $time;
    check("b2b_gap", 32'((t2 - t1) / 10), 32'd9);
    check("bcd_200", 32'(bcd3), 32'h200);
    @(posedge clk); #1;

    start  = 1'b1;
    bin_in = 8'd123;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy3), 32'd0);
    check("mid_rst_done", 32'(done3), 32'd0);
    check("mid_rst_bcd",  32'(bcd3),  32'd0);
    check("mid_rst_ovf",  32'(ovf3),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(8'd58, 1'b0, e, b);
    check("bcd_after_rst", 32'(bcd3), 32'h058);
    @(posedge clk); #1;

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), 1'b0, e, b);
      check("sweep_lat", 32'(e), 32'd8);
      check("sweep_bcd", 32'(bcd3), bcd_of(v, 3));
    end
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_conv(8'($urandom), 1'($urandom), e, b);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
